ble_packet_tx: RTL



---
 rtl/ble_packet_tx_if.sv | 43 ++++
 rtl/ble_packet_tx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ble_packet_tx_if.sv
// ---------------------------------------------------------------------------
// ble_packet_tx_if
// Host-side bundle for the BLE 1M packet transmitter.
//   start        : one-cycle packet request (host -> tx)
//   access_addr  : 32-bit access address, latched on start
//   channel      : whitening channel index 0..39, latched on start
//   pdu_len      : PDU length in bytes incl. 2-byte header (2..39)
//   byte_in      : PDU byte offered by the host
//   byte_valid   : byte_in valid
//   byte_ready   : holding register empty while a packet is in progress
//   update/value : bit-period strobe and current on-air bit
//   busy/done    : packet in progress / one-cycle completion pulse
//   error        : one-cycle pulse on bad length or byte underflow
//   tx_en        : I/Q valid
//   I_out/Q_out  : 4-bit square-wave quadrature samples
// ---------------------------------------------------------------------------
interface ble_packet_tx_if;
  logic        start;
  logic [31:0] access_addr;
  logic [5:0]  channel;
  logic [5:0]  pdu_len;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        update;
  logic        value;
  logic        busy;
  logic        done;
  logic        error;
  logic        tx_en;
  logic [3:0]  I_out;
  logic [3:0]  Q_out;

  modport master (
    output start, access_addr, channel, pdu_len, byte_in, byte_valid,
    input  byte_ready, update, value, busy, done, error, tx_en, I_out, Q_out
  );

  modport slave (
    input  start, access_addr, channel, pdu_len, byte_in, byte_valid,
    output byte_ready, update, value, busy, done, error, tx_en, I_out, Q_out
  );
endinterface

// File: rtl/ble_packet_tx.sv
// ---------------------------------------------------------------------------
// ble_packet_tx
// Builds a BLE 1M packet (preamble, access address, whitened PDU, whitened
// CRC24) from a host byte stream and serialises it at one bit per
// SAMPLES_PER_BIT clocks, with a square-wave FSK I/Q rendering of the stream.
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : ble_packet_tx_if.slave (host handshake, bit stream, status, I/Q)
// ---------------------------------------------------------------------------
module ble_packet_tx #(
  parameter int          SAMPLES_PER_BIT = 16,
  parameter logic [23:0] CRC_INIT        = 24'h555555
) (
  input  logic           clk,
  input  logic           rst,
  ble_packet_tx_if.slave bus
);
  localparam int            SW          = $clog2(SAMPLES_PER_BIT);
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLES_PER_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_ACCESS, S_PDU, S_CRC} state_t;

  state_t        r_state, w_state_next;
  logic [8:0]    r_cnt, w_cnt_next;       // bit index inside the current field
  logic [SW-1:0] r_sample;                // clock index inside the bit period
  logic [31:0]   r_aa;
  logic [5:0]    r_len;
  logic [7:0]    r_byte_sr;               // PDU byte currently on air
  logic [7:0]    r_hold;                  // host holding register
  logic          r_full;
  logic [23:0]   r_crc, w_crc_step;
  logic [6:0]    r_white, w_white_step;   // bit i = whitening position i
  logic          r_value, r_busy, r_done, r_error;
  logic [5:0]    r_phase;

  logic       w_bit_end, w_xfer, w_start_ok, w_bad_len, w_pull, w_underflow;
  logic       w_finish, w_load, w_raw, w_whiten, w_value_next, w_crc_fb, w_aa0;
  logic [8:0] w_pdu_last;

  assign w_bit_end  = r_busy && (r_sample == SAMPLE_LAST);
  assign w_xfer     = bus.byte_valid && bus.byte_ready;
  assign w_pdu_last = {r_len, 3'b000} - 9'd1;
  // The first preamble bit is produced before access_addr has been latched.
  assign w_aa0      = (r_state == S_IDLE) ? bus.access_addr[0] : r_aa[0];

  // Next-state / field sequencing
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_start_ok   = 1'b0;
    w_bad_len    = 1'b0;
    w_pull       = 1'b0;
    w_underflow  = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.pdu_len < 6'd2 || bus.pdu_len > 6'd39) begin
            w_bad_len = 1'b1;
          end else begin
            w_start_ok   = 1'b1;
            w_state_next = S_PREAMBLE;
            w_cnt_next   = '0;
          end
        end
      end
      S_PREAMBLE: begin
        if (w_bit_end) begin
          if (r_cnt == 9'd7) begin
            w_state_next = S_ACCESS;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 9'd1;
          end
        end
      end
      S_ACCESS: begin
        if (w_bit_end) begin
          w_cnt_next = (r_cnt == 9'd31) ? 9'd0 : r_cnt + 9'd1;
          if (r_cnt == 9'd31) begin
            w_pull       = 1'b1;
            w_state_next = r_full ? S_PDU : S_IDLE;
            w_underflow  = !r_full;
          end
        end
      end
      S_PDU: begin
        if (w_bit_end) begin
          if (r_cnt == w_pdu_last) begin
            w_state_next = S_CRC;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 9'd1;
            if (r_cnt[2:0] == 3'd7) begin
              w_pull = 1'b1;
              if (!r_full) begin
                w_underflow  = 1'b1;
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
              end
            end
          end
        end
      end
      S_CRC: begin
        if (w_bit_end) begin
          if (r_cnt == 9'd23) begin
            w_finish     = 1'b1;
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 9'd1;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Unwhitened bit for the period that starts after this edge
  always_comb begin
    w_raw    = 1'b0;
    w_whiten = 1'b0;
    case (w_state_next)
      S_PREAMBLE: w_raw = w_cnt_next[0] ^ w_aa0;  // alternates into AA[0]
      S_ACCESS:   w_raw = r_aa[w_cnt_next[4:0]];
      S_PDU: begin
        w_raw    = w_pull ? r_hold[0] : r_byte_sr[w_cnt_next[2:0]];
        w_whiten = 1'b1;
      end
      S_CRC: begin
        // Frozen CRC goes out from position 23 down to position 0.
        w_raw    = r_crc[5'd23 - w_cnt_next[4:0]];
        w_whiten = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_load       = w_start_ok || w_bit_end;
  assign w_value_next = w_raw ^ (w_whiten & r_white[6]);
  assign w_crc_fb     = w_raw ^ r_crc[23];
  assign w_crc_step   = {r_crc[22:0], w_crc_fb} ^ (w_crc_fb ? 24'h00065A : 24'h000000);
  // x^7+x^4+1: position 6 feeds back into position 0 and is XORed into 4.
  assign w_white_step = {r_white[5:4], r_white[3] ^ r_white[6], r_white[2:0], r_white[6]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_sample  <= '0;
      r_aa      <= '0;
      r_len     <= '0;
      r_byte_sr <= '0;
      r_hold    <= '0;
      r_full    <= 1'b0;
      r_crc     <= CRC_INIT;
      r_white   <= 7'h01;
      r_value   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_phase   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_busy  <= (w_state_next != S_IDLE);
      r_done  <= w_finish;
      r_error <= w_bad_len | w_underflow;

      if (w_state_next == S_IDLE || !r_busy || r_sample == SAMPLE_LAST)
        r_sample <= '0;
      else
        r_sample <= r_sample + SW'(1);

      if (w_load)
        r_value <= w_value_next;

      if (w_start_ok) begin
        r_aa    <= bus.access_addr;
        r_len   <= bus.pdu_len;
        r_crc   <= CRC_INIT;
        // position0 = 1, positions 1..6 = channel[5]..channel[0]
        r_white <= {bus.channel[0], bus.channel[1], bus.channel[2],
                    bus.channel[3], bus.channel[4], bus.channel[5], 1'b1};
      end else if (w_load) begin
        if (w_state_next == S_PDU)
          r_crc <= w_crc_step;
        if (w_whiten)
          r_white <= w_white_step;
      end

      if (w_pull && r_full)
        r_byte_sr <= r_hold;
      if (w_xfer)
        r_hold <= bus.byte_in;

      // A transfer coinciding with a pull leaves the register full.
      if (w_state_next == S_IDLE) r_full <= 1'b0;
      else if (w_xfer)            r_full <= 1'b1;
      else if (w_pull)            r_full <= 1'b0;

      if (w_state_next == S_IDLE) r_phase <= '0;
      else if (r_busy)            r_phase <= r_value ? r_phase + 6'd1 : r_phase - 6'd1;
    end
  end

  assign bus.byte_ready = !r_full && r_busy;
  assign bus.update     = r_busy && (r_sample == '0);
  assign bus.value      = r_value;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.error      = r_error;
  assign bus.tx_en      = r_busy;
  assign bus.I_out      = (r_busy && !r_phase[5]) ? 4'd15 : 4'd0;
  // (phase+16)[5] equals phase[5]^phase[4]: the +16 carries into bit 5 iff bit 4 is set.
  assign bus.Q_out      = (r_busy && !(r_phase[5] ^ r_phase[4])) ? 4'd15 : 4'd0;
endmodule
